// File: rtl/voting_machine_param.sv
// voting_machine_param: N-candidate ballot counter with valid/ready vote handshake and a sequential tally.
// Optional one-vote-per-voter lock-out is built when VOTER_LOCK_EN is defined.

module voting_machine_param #(
    parameter int  NUM_CAND   = 4,
    parameter int  CNT_W      = 8,
    parameter int  VOTER_ID_W = 4,
    localparam int IDX_W      = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    localparam int TOT_W      = CNT_W + IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  admin_mode,
    input  logic                  clear,
    input  logic                  vote_valid,
    input  logic [NUM_CAND-1:0]   vote_sel,
    input  logic [VOTER_ID_W-1:0] voter_id,
    output logic                  vote_ready,
    output logic                  vote_ack,
    output logic                  vote_nack,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [CNT_W-1:0]      rd_count,
    output logic [TOT_W-1:0]      total_votes,
    output logic [IDX_W-1:0]      winner_idx,
    output logic                  tie,
    output logic                  result_valid,
    output logic [2:0]            state_out
);

    // state   | meaning
    // IDLE    | election closed; clear honoured here
    // VOTING  | ballots accepted (vote_ready high)
    // CLOSED  | polls shut, waiting for admin tally or reopen
    // TALLY   | one candidate compared per cycle, NUM_CAND cycles
    // RESULT  | winner_idx/tie valid until admin_mode drops
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VOTING = 3'd1,
        S_CLOSED = 3'd2,
        S_TALLY  = 3'd3,
        S_RESULT = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] count_q [NUM_CAND];
    logic [TOT_W-1:0] total_q;
    logic             ack_q, nack_q;
    logic [IDX_W-1:0] winner_q;
    logic             tie_q;

    logic [IDX_W-1:0] tally_rem_q;
    logic [CNT_W-1:0] tally_max_q, tally_max_d;
    logic [IDX_W-1:0] tally_idx_q, tally_idx_d;
    logic             tally_tie_q, tally_tie_d;
    logic [IDX_W-1:0] tally_k;
    logic [CNT_W-1:0] tally_cur;
    logic             tally_done;

    logic [IDX_W-1:0] sel_idx;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_onehot;
    logic             voter_locked;
    logic             xfer, accept, clear_now;

    always_comb begin
        sel_idx = '0;
        sel_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_sel[i]) begin
                sel_idx = IDX_W'(i);
                sel_cnt = count_q[i];
            end
        end
    end

    assign sel_onehot = $onehot(vote_sel);
    assign xfer       = vote_valid && (state_q == S_VOTING);
    assign accept     = xfer && sel_onehot && (sel_cnt != '1) && !voter_locked;
    assign clear_now  = clear && (state_q == S_IDLE);

`ifdef VOTER_LOCK_EN
    logic [2**VOTER_ID_W-1:0] voted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_q <= '0;
        end else if (clear_now) begin
            voted_q <= '0;
        end else if (accept) begin
            voted_q[voter_id] <= 1'b1;
        end
    end

    assign voter_locked = voted_q[voter_id];
`else
    logic voter_id_unused;
    assign voter_id_unused = ^voter_id;
    assign voter_locked    = 1'b0;
`endif

    // Tally walks candidates in ascending order while the down-counter runs to zero.
    assign tally_k    = IDX_W'(NUM_CAND - 1) - tally_rem_q;
    assign tally_done = (state_q == S_TALLY) && (tally_rem_q == '0);

    always_comb begin
        tally_cur = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (tally_k == IDX_W'(i)) tally_cur = count_q[i];
        end
    end

    always_comb begin
        tally_max_d = tally_max_q;
        tally_idx_d = tally_idx_q;
        tally_tie_d = tally_tie_q;
        if (tally_cur > tally_max_q) begin
            tally_max_d = tally_cur;
            tally_idx_d = tally_k;
            tally_tie_d = 1'b0;
        end else if (tally_cur == tally_max_q && tally_k != '0) begin
            tally_tie_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_VOTING;
            S_VOTING: if (!enable) state_d = S_CLOSED;
            S_CLOSED: begin
                if (admin_mode)  state_d = S_TALLY;
                else if (enable) state_d = S_VOTING;
            end
            S_TALLY:  if (tally_rem_q == '0) state_d = S_RESULT;
            S_RESULT: if (!admin_mode) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= accept;
            nack_q  <= xfer && !accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CAND; i++) count_q[i] <= '0;
            total_q <= '0;
        end else if (clear_now) begin
            for (int i = 0; i < NUM_CAND; i++) count_q[i] <= '0;
            total_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (sel_idx == IDX_W'(i)) count_q[i] <= count_q[i] + CNT_W'(1);
            end
            total_q <= total_q + TOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally_rem_q <= '0;
            tally_max_q <= '0;
            tally_idx_q <= '0;
            tally_tie_q <= 1'b0;
            winner_q    <= '0;
            tie_q       <= 1'b0;
        end else if (state_q != S_TALLY) begin
            tally_rem_q <= IDX_W'(NUM_CAND - 1);
            tally_max_q <= '0;
            tally_idx_q <= '0;
            tally_tie_q <= 1'b0;
        end else begin
            tally_rem_q <= tally_rem_q - IDX_W'(1);
            tally_max_q <= tally_max_d;
            tally_idx_q <= tally_idx_d;
            tally_tie_q <= tally_tie_d;
            if (tally_done) begin
                winner_q <= tally_idx_d;
                tie_q    <= tally_tie_d;
            end
        end
    end

    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (rd_idx == IDX_W'(i)) rd_count = count_q[i];
        end
    end

    assign vote_ready   = (state_q == S_VOTING);
    assign result_valid = (state_q == S_RESULT);
    assign vote_ack     = ack_q;
    assign vote_nack    = nack_q;
    assign total_votes  = total_q;
    assign winner_idx   = winner_q;
    assign tie          = tie_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_voting_machine_param.sv
// tb_voting_machine_param: directed and randomized ballots checked against a behavioural tally model.

module tb_voting_machine_param;

    localparam int NC   = 4;
    localparam int CW   = 4;
    localparam int VW   = 4;
    localparam int IW   = 2;
    localparam int TW   = CW + IW;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk, rst, enable, admin_mode, clear, vote_valid;
    logic [NC-1:0] vote_sel;
    logic [VW-1:0] voter_id;
    logic          vote_ready, vote_ack, vote_nack, tie, result_valid;
    logic [IW-1:0] rd_idx, winner_idx;
    logic [CW-1:0] rd_count;
    logic [TW-1:0] total_votes;
    logic [2:0]    state_out;

    voting_machine_param #(.NUM_CAND(NC), .CNT_W(CW), .VOTER_ID_W(VW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .admin_mode(admin_mode), .clear(clear),
        .vote_valid(vote_valid), .vote_sel(vote_sel), .voter_id(voter_id),
        .vote_ready(vote_ready), .vote_ack(vote_ack), .vote_nack(vote_nack),
        .rd_idx(rd_idx), .rd_count(rd_count), .total_votes(total_votes),
        .winner_idx(winner_idx), .tie(tie), .result_valid(result_valid), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt [NC];
    int m_total;
    bit m_voted [1 << VW];
    int vid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        for (int i = 0; i < (1 << VW); i++) m_voted[i] = 1'b0;
        m_total = 0;
    endtask

    function automatic bit m_accept(input logic [NC-1:0] sel, input logic [VW-1:0] id);
        int k;
        if ($countones(sel) != 1) return 1'b0;
        k = 0;
        for (int i = 0; i < NC; i++) if (sel[i]) k = i;
        if (m_cnt[k] >= MAXC) return 1'b0;
`ifdef VOTER_LOCK_EN
        if (m_voted[id]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Highest count wins, lowest index on ties; tie means the maximum is shared.
    task automatic m_winner(output int widx, output int wtie);
        int mx, nmx;
        mx = -1;
        widx = 0;
        for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) begin mx = m_cnt[i]; widx = i; end
        nmx = 0;
        for (int i = 0; i < NC; i++) if (m_cnt[i] == mx) nmx++;
        wtie = (nmx > 1) ? 1 : 0;
    endtask

    task automatic vote(input logic [NC-1:0] sel, input logic [VW-1:0] id);
        bit exp;
        vote_valid = 1'b1;
        vote_sel   = sel;
        voter_id   = id;
        exp = m_accept(sel, id);
        tick();
        chk("vote_ack", vote_ack, exp);
        chk("vote_nack", vote_nack, !exp);
        if (exp) begin
            for (int i = 0; i < NC; i++) if (sel[i]) m_cnt[i]++;
            m_total++;
            m_voted[id] = 1'b1;
        end
        chk("total_votes", total_votes, m_total);
    endtask

    task automatic quiet(input string tag);
        vote_valid = 1'b0;
        tick();
        chk({tag, "_ack"}, vote_ack, 0);
        chk({tag, "_nack"}, vote_nack, 0);
    endtask

    task automatic chk_counts();
        for (int i = 0; i < NC; i++) begin
            rd_idx = IW'(i);
            #1;
            chk("rd_count", rd_count, m_cnt[i]);
        end
        chk("total_votes", total_votes, m_total);
    endtask

    task automatic open_poll();
        enable = 1'b1;
        tick();
        chk("state_voting", state_out, 1);
        chk("vote_ready", vote_ready, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_reset();
        chk_counts();
    endtask

    task automatic fill(input int c0, input int c1, input int c2, input int c3);
        int c [NC];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < NC; k++)
            for (int j = 0; j < c[k]; j++) begin
                vote(NC'(1 << k), VW'(vid));
                vid = (vid + 1) % (1 << VW);
            end
        quiet("fill_end");
    endtask

    // From VOTING: close, tally, check result; drop_at >= 0 releases admin_mode mid-tally.
    task automatic tally(input int drop_at, input bit en_hold);
        int n, widx, wtie;
        enable     = 1'b0;
        vote_valid = 1'b0;
        tick();
        chk("state_closed", state_out, 2);
        chk("ready_closed", vote_ready, 0);
        admin_mode = 1'b1;
        enable     = en_hold;
        tick();
        chk("state_tally", state_out, 3);
        n = 0;
        while (state_out == 3'd3 && n < 40) begin
            if (n == drop_at) admin_mode = 1'b0;
            tick();
            n++;
        end
        chk("tally_len", n, NC);
        m_winner(widx, wtie);
        chk("state_result", state_out, 4);
        chk("result_valid", result_valid, 1);
        chk("winner_idx", winner_idx, widx);
        chk("tie", tie, wtie);
        admin_mode = 1'b0;
        enable     = 1'b0;
        tick();
        chk("state_idle", state_out, 0);
        chk("result_valid_off", result_valid, 0);
        chk("winner_hold", winner_idx, widx);
        chk("tie_hold", tie, wtie);
        chk_counts();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; admin_mode = 1'b0; clear = 1'b0;
        vote_valid = 1'b0; vote_sel = '0; voter_id = '0; rd_idx = '0;
        m_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_state", state_out, 0);
        chk("rst_ready", vote_ready, 0);
        chk("rst_ack", vote_ack, 0);
        chk("rst_nack", vote_nack, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_winner", winner_idx, 0);
        chk("rst_tie", tie, 0);
        chk_counts();

        // Vote in IDLE is ignored.
        vote_valid = 1'b1; vote_sel = 4'b0001;
        tick();
        quiet("idle_vote");
        chk_counts();

        open_poll();
        vote(4'b0001, 0); vote(4'b0010, 1); vote(4'b0010, 2); vote(4'b0100, 3);
        quiet("b2b_end");
        chk_counts();

        vote(4'b0000, 4); vote(4'b0011, 5); vote(4'b1111, 6);
        quiet("bad_sel_end");
        chk_counts();

        // clear outside IDLE is ignored.
        clear = 1'b1;
        vote(4'b1000, 7);
        clear = 1'b0;
        quiet("clear_voting");
        chk_counts();

        // Vote in the cycle enable drops is still handled; then reopen from CLOSED.
        enable = 1'b0;
        vote(4'b0001, 8);
        chk("state_closed_vote", state_out, 2);
        vote_valid = 1'b1; vote_sel = 4'b0001;
        tick();
        chk("closed_ignore_ack", vote_ack, 0);
        chk("closed_ignore_nack", vote_nack, 0);
        vote_valid = 1'b0;
        enable = 1'b1;
        tick();
        chk("closed_reopen", state_out, 1);
        chk_counts();

        // Saturation on candidate 3.
        for (int j = 0; j < MAXC + 2; j++) vote(4'b1000, VW'(j));
        quiet("sat_end");
        chk_counts();

        // admin_mode wins over enable in CLOSED.
        tally(-1, 1'b1);

        do_clear();
        open_poll();
        tally(-1, 1'b0);

        do_clear();
        open_poll();
        fill(5, 7, 7, 1);
        tally(1, 1'b0);

        do_clear();
        open_poll();
        fill(2, 9, 3, 0);
        tally(-1, 1'b0);

        // Same voter twice: with the lock the second is refused.
        do_clear();
        open_poll();
        vote(4'b0001, 3);
        vote(4'b0010, 3);
        quiet("lock_end");
        chk_counts();
        tally(-1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) do_clear();
            open_poll();
            for (int c = 0; c < 40; c++) begin
                clear = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 9) < 7) vote(NC'(1 << $urandom_range(0, NC - 1)), VW'($urandom_range(0, 15)));
                    else vote(NC'($urandom_range(0, 15)), VW'($urandom_range(0, 15)));
                end else begin
                    quiet("rand_idle");
                end
            end
            clear = 1'b0;
            quiet("rand_end");
            chk_counts();
            tally(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, NC - 1)), 1'b0);
        end

        // Reset in the middle of a tally, with a nonzero winner on record.
        do_clear();
        open_poll();
        fill(0, 0, 3, 1);
        tally(-1, 1'b0);
        open_poll();
        enable = 1'b0;
        tick();
        admin_mode = 1'b1;
        tick(); tick();
        chk("pre_rst_state", state_out, 3);
        rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_state", state_out, 0);
        chk("mid_rst_result_valid", result_valid, 0);
        chk("mid_rst_winner", winner_idx, 0);
        chk("mid_rst_tie", tie, 0);
        chk("mid_rst_ack", vote_ack, 0);
        chk("mid_rst_nack", vote_nack, 0);
        chk_counts();
        admin_mode = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_state", state_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
